// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory (combinational read) between two
//   requesters. Port 0 (CPU MEM stage) has fixed priority; port 1 (loader/DMA)
//   is granted once after MAX_BURST consecutive contended port-0 grants, so a
//   stream of port-0 accesses cannot starve it. One memory access per cycle.
//   A read's response is registered on the posedge that ends its grant cycle.
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   Adds input m1_lock. While port 1 already owns the memory and keeps both
//   m1_req and m1_lock high, it keeps winning regardless of m0_req.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mK_req/we/addr/wdata       request command for port K (held until mK_gnt)
//   mK_gnt                     combinational grant, access performed this cycle
//   mK_rvalid/rdata            registered read response (1-cycle pulse / held)
//   m1_lock                    (DMEM_ARB_LOCK_EN only) port 1 ownership lock
//   mem_read/write/address/write_data  drive to the data memory
//   mem_read_data              combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        w_gnt0, w_gnt1;
  logic        w_same, w_raw0, w_raw1, w_lock_hold;

  // Same-address write/read pair: the write goes first so the read sees
  // the new data on the following cycle.
  assign w_same = (m0_addr == m1_addr);
  assign w_raw0 = w_same & m0_we & ~m1_we;
  assign w_raw1 = w_same & m1_we & ~m0_we;

`ifdef DMEM_ARB_LOCK_EN
  assign w_lock_hold = (r_state == OWN1) & m1_lock & m1_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Arbitration, next state and burst counter.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    if (rst_n) begin
      if (w_lock_hold)          w_gnt1 = 1'b1;
      else if (m0_req & ~m1_req) w_gnt0 = 1'b1;
      else if (m1_req & ~m0_req) w_gnt1 = 1'b1;
      else if (m0_req & m1_req) begin
        if (w_raw0)                                   w_gnt0 = 1'b1;
        // Port 1 write-first is skipped when port 1 just won, so it can
        // never take two contended cycles in a row.
        else if (w_raw1 && r_state != OWN1)           w_gnt1 = 1'b1;
        else if (r_state == OWN0 && r_cnt == CAP)     w_gnt1 = 1'b1;
        else                                          w_gnt0 = 1'b1;
      end
    end
    if (w_gnt0)      w_state_nxt = OWN0;
    else if (w_gnt1) w_state_nxt = OWN1;
    // The count only advances while port 0 already owned the memory, so a
    // burst that starts from IDLE or after a port-1 grant is MAX_BURST long.
    if (r_state == OWN0 && w_gnt0 && m1_req)
      w_cnt_nxt = (r_cnt == CAP) ? r_cnt : r_cnt + 8'd1;
  end

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Memory drive: winner's command, all zero when nobody is granted.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (w_gnt0) begin
      mem_read       = ~m0_we;
      mem_write      = m0_we;
      mem_address    = m0_addr;
      mem_write_data = m0_wdata;
    end else if (w_gnt1) begin
      mem_read       = ~m1_we;
      mem_write      = m1_we;
      mem_address    = m1_addr;
      mem_write_data = m1_wdata;
    end
  end

  // Read response registers, one set per port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= w_gnt0 & ~m0_we;
      m1_rvalid <= w_gnt1 & ~m1_we;
      if (w_gnt0 & ~m0_we) m0_rdata <= mem_read_data;
      if (w_gnt1 & ~m1_we) m1_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [9:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        m1_lock = 1'b0;
`endif
  logic        mem_read, mem_write;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] tbmem  [0:1023];
  logic [31:0] refmem [0:1023];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write on the rising edge.
  assign mem_read_data = tbmem[mem_address];
  always @(posedge clk) if (mem_write) tbmem[mem_address] <= mem_write_data;

  task automatic set_lock(input bit v);
`ifdef DMEM_ARB_LOCK_EN
    m1_lock = v;
`endif
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    set_lock(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 0; m0_addr = 10'h001;
    m1_req = 1; m1_we = 1; m1_addr = 10'h002; m1_wdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL reset_gnt got=%b want=00", {m0_gnt, m1_gnt}); else pass_cnt++;
    chk_cnt++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_memrw got=%b want=00", {mem_read, mem_write}); else pass_cnt++;
    chk_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid got=%b want=00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
    chk_cnt++; if (mem_address !== 10'h0 || mem_write_data !== 32'h0) $display("FAIL reset_memaddr got=%h/%h want=0/0", mem_address, mem_write_data); else pass_cnt++;
    idle_inputs();
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk_cnt++; if ({mem_read, mem_write, mem_address, mem_write_data} !== '0)
      $display("FAIL idle_mem got=%b%b %h %h want=all 0", mem_read, mem_write, mem_address, mem_write_data); else pass_cnt++;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
    #1;
    chk_cnt++; if (m0_gnt !== 1'b1 || mem_write !== 1'b1 || mem_address !== 10'h005 || mem_write_data !== 32'hDEADBEEF)
      $display("FAIL wr_grant got=%b%b %h %h want=1 1 005 deadbeef", m0_gnt, mem_write, mem_address, mem_write_data); else pass_cnt++;
    @(negedge clk);
    m0_we = 0; #1;
    chk_cnt++; if (m0_gnt !== 1'b1 || mem_read !== 1'b1) $display("FAIL rd_grant got=%b%b want=11", m0_gnt, mem_read); else pass_cnt++;
    chk_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got=%b want=0", m0_rvalid); else pass_cnt++;
    @(negedge clk);
    idle_inputs(); #1;
    chk_cnt++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF)
      $display("FAIL rd_data got=%b %h want=1 deadbeef", m0_rvalid, m0_rdata); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF)
      $display("FAIL rd_hold got=%b %h want=0 deadbeef", m0_rvalid, m0_rdata); else pass_cnt++;
  endtask

  // Both ports held for n cycles starting from IDLE; first grant order compared.
  task automatic test_burst(input int n);
    int exp_order[10];
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    idle_inputs();
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 10'h020;
    m1_req = 1; m1_we = 0; m1_addr = 10'h021;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk_cnt++;
      if ({m0_gnt, m1_gnt} !== ((exp_order[c] == 1) ? 2'b01 : 2'b10))
        $display("FAIL burst_order cycle=%0d got=%b%b want_port=%0d", c, m0_gnt, m1_gnt, exp_order[c]);
      else pass_cnt++;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_raw();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 10'h3FF; m0_wdata = 32'h12345678;
    m1_req = 1; m1_we = 0; m1_addr = 10'h3FF;
    #1;
    chk_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL raw_first got=%b%b want=10", m0_gnt, m1_gnt); else pass_cnt++;
    @(negedge clk);
    m0_req = 0; #1;
    chk_cnt++; if (m1_gnt !== 1'b1 || mem_read !== 1'b1) $display("FAIL raw_second got=%b%b want=11", m1_gnt, mem_read); else pass_cnt++;
    @(negedge clk);
    idle_inputs(); #1;
    chk_cnt++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12345678)
      $display("FAIL raw_data got=%b %h want=1 12345678", m1_rvalid, m1_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m1_req = 1; m1_we = 0; m1_addr = 10'h005;
    #1;
    chk_cnt++; if (m1_gnt !== 1'b1) $display("FAIL rstmid_gnt got=%b want=1", m1_gnt); else pass_cnt++;
    #1 rst_n = 0;
    @(negedge clk);
    idle_inputs(); #1;
    chk_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL rstmid_rvalid0 got=%b want=0", m1_rvalid); else pass_cnt++;
    rst_n = 1;
    @(negedge clk); #1;
    chk_cnt++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0)
      $display("FAIL rstmid_after got=%b %h want=0 0", m1_rvalid, m1_rdata); else pass_cnt++;
    // State restarted in IDLE: a contended run again yields four port-0 grants first.
    test_burst(5);
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    m1_req = 1; m1_we = 0; m1_addr = 10'h040; set_lock(1'b1);
    #1;
    chk_cnt++; if (m1_gnt !== 1'b1) $display("FAIL lock_own got=%b want=1", m1_gnt); else pass_cnt++;
    m0_req = 1; m0_we = 0; m0_addr = 10'h041;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk_cnt++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL lock_hold cycle=%0d got=%b%b want=01", c, m0_gnt, m1_gnt); else pass_cnt++;
    end
    @(negedge clk);
    set_lock(1'b0); #1;
    chk_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL lock_drop got=%b%b want=10", m0_gnt, m1_gnt); else pass_cnt++;
    @(negedge clk); idle_inputs();
  endtask
`endif

  // Random traffic against a cycle-level reference model of the arbitration
  // rules and a separate reference memory.
  task automatic test_random(input int cycles);
    bit r0 = 0, w0 = 0, r1 = 0, w1 = 0, lk = 0, pend0 = 0, pend1 = 0, lock_on;
    logic [9:0]  a0 = 0, a1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    bit          e_v0 = 0, e_v1 = 0;
    logic [31:0] e_d0 = 0, e_d1 = 0;
    int last = -1;   // owner of the previous cycle, -1 = nobody
    int streak = 0;  // contended port-0 grants counted while port 0 keeps ownership
    int win;
    @(negedge clk); rst_n = 0; idle_inputs();
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk_cnt++; if (m0_rvalid !== e_v0 || (e_v0 && m0_rdata !== e_d0) || m0_rdata !== e_d0)
        $display("FAIL rand_rsp0 cyc=%0d got=%b %h want=%b %h", c, m0_rvalid, m0_rdata, e_v0, e_d0); else pass_cnt++;
      chk_cnt++; if (m1_rvalid !== e_v1 || m1_rdata !== e_d1)
        $display("FAIL rand_rsp1 cyc=%0d got=%b %h want=%b %h", c, m1_rvalid, m1_rdata, e_v1, e_d1); else pass_cnt++;
      if (!pend0 || $urandom_range(0, 7) == 0) begin
        r0 = ($urandom_range(0, 2) != 0); w0 = 1'($urandom_range(0, 1));
        a0 = 10'(16 + $urandom_range(0, 7)); d0 = $urandom;
      end
      if (!pend1 || $urandom_range(0, 7) == 0) begin
        r1 = ($urandom_range(0, 2) != 0); w1 = 1'($urandom_range(0, 1));
        a1 = 10'(16 + $urandom_range(0, 7)); d1 = $urandom;
      end
      lk = 1'($urandom_range(0, 1));
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      set_lock(lk);
      #1;
`ifdef DMEM_ARB_LOCK_EN
      lock_on = (last == 1) && lk && r1;
`else
      lock_on = 0;
`endif
      if (lock_on)                                  win = 1;
      else if (!r0 && !r1)                          win = -1;
      else if (r0 != r1)                            win = r0 ? 0 : 1;
      else if (a0 == a1 && w0 && !w1)               win = 0;
      else if (a0 == a1 && w1 && !w0 && last != 1)  win = 1;
      else if (last == 0 && streak == MAXB - 1)     win = 1;
      else                                          win = 0;
      chk_cnt++; if (m0_gnt !== (win == 0) || m1_gnt !== (win == 1))
        $display("FAIL rand_gnt cyc=%0d got=%b%b want_port=%0d", c, m0_gnt, m1_gnt, win); else pass_cnt++;
      e_v0 = (win == 0) && !w0;
      e_v1 = (win == 1) && !w1;
      if (e_v0) e_d0 = refmem[a0];
      if (e_v1) e_d1 = refmem[a1];
      if (win == 0 && w0) refmem[a0] = d0;
      if (win == 1 && w1) refmem[a1] = d1;
      pend0 = r0 && (win != 0);
      pend1 = r1 && (win != 1);
      if (win == 0 && r1 && last == 0) streak = (streak + 1 > MAXB - 1) ? MAXB - 1 : streak + 1;
      else streak = 0;
      last = win;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tbmem[i]  = 32'h0;
      refmem[i] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_burst(10);
    test_raw();
    test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    test_random(400);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
